// File: rtl/brick_pkg.sv
// Shared constants for the brick grid collider: paddle zone codes, FSM state codes,
// default brick pitch and a constant-evaluable ceil(log2) helper.
package brick_pkg;

  localparam logic [1:0] ZONE_LEFT   = 2'd0;
  localparam logic [1:0] ZONE_CENTRE = 2'd1;
  localparam logic [1:0] ZONE_RIGHT  = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam int DEF_PITCH_X = 128;
  localparam int DEF_PITCH_Y = 24;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Strict-inequality axis-aligned box overlap with per-axis penetration depths.
// Sums are one bit wider than the inputs so a box near the top of the range never wraps.
module aabb_overlap #(
  parameter int W = 10
) (
  input  logic [W-1:0] a_x_i,
  input  logic [W-1:0] a_y_i,
  input  logic [W-1:0] a_w_i,
  input  logic [W-1:0] a_h_i,
  input  logic [W-1:0] b_x_i,
  input  logic [W-1:0] b_y_i,
  input  logic [W-1:0] b_w_i,
  input  logic [W-1:0] b_h_i,
  output logic         overlap_o,
  output logic [W:0]   ox_o,
  output logic [W:0]   oy_o
);

  logic [W:0] a_l, a_t, a_r, a_b;
  logic [W:0] b_l, b_t, b_r, b_b;
  logic [W:0] right_min, left_max, bot_min, top_max;
  logic       nonempty;

  always_comb begin
    a_l = {1'b0, a_x_i};
    a_t = {1'b0, a_y_i};
    b_l = {1'b0, b_x_i};
    b_t = {1'b0, b_y_i};
    a_r = a_l + {1'b0, a_w_i};
    a_b = a_t + {1'b0, a_h_i};
    b_r = b_l + {1'b0, b_w_i};
    b_b = b_t + {1'b0, b_h_i};
    // A zero-size box has no interior; without this a strict test could still pass.
    nonempty  = (a_w_i != '0) && (a_h_i != '0) && (b_w_i != '0) && (b_h_i != '0);
    overlap_o = nonempty && (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);
    right_min = (a_r < b_r) ? a_r : b_r;
    left_max  = (a_l > b_l) ? a_l : b_l;
    bot_min   = (a_b < b_b) ? a_b : b_b;
    top_max   = (a_t > b_t) ? a_t : b_t;
    ox_o      = right_min - left_max;
    oy_o      = bot_min - top_max;
  end

endmodule

// File: rtl/brick_grid_collider.sv
// Frame-based ball/brick/paddle collider: one brick per cycle sequential scan of a
// ROWS x COLS grid, clearing the first struck live brick and reporting bounce axes.
module brick_grid_collider
  import brick_pkg::*;
#(
  parameter int COLS    = 5,
  parameter int ROWS    = 2,
  parameter int PITCH_X = DEF_PITCH_X,
  parameter int PITCH_Y = DEF_PITCH_Y,
  parameter int W       = 10,
  localparam int N      = ROWS * COLS,
  localparam int IDX_W  = (N > 1) ? clog2(N) : 1,
  localparam int CNT_W  = clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_level,
  input  logic [N-1:0]     level_mask,
  input  logic [W-1:0]     grid_x,
  input  logic [W-1:0]     grid_y,
  input  logic [W-1:0]     block_w,
  input  logic [W-1:0]     block_h,
  input  logic [W-1:0]     ball_x,
  input  logic [W-1:0]     ball_y,
  input  logic [W-1:0]     ball_w,
  input  logic [W-1:0]     ball_h,
  input  logic [W-1:0]     paddle_x,
  input  logic [W-1:0]     paddle_y,
  input  logic [W-1:0]     paddle_w,
  input  logic [W-1:0]     paddle_h,
  output logic             busy,
  output logic             done,
  output logic             hit_valid,
  output logic [IDX_W-1:0] hit_idx,
  output logic             flip_x,
  output logic             flip_y,
  output logic             paddle_hit,
  output logic [1:0]       paddle_zone,
  output logic [N-1:0]     alive,
  output logic [CNT_W-1:0] bricks_left,
  output logic             all_clear,
  output logic [1:0]       state_dbg
);

  // start is a one-cycle request honoured only in IDLE; done is a one-cycle
  // completion pulse and the hit/paddle results stay stable until the next accepted start.

  localparam logic [W:0] STEP_X = (W + 1)'(PITCH_X);
  localparam logic [W:0] STEP_Y = (W + 1)'(PITCH_Y);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [W:0]       x_q, x_d, y_q, y_d;
  logic [W-1:0]     gx_q, gx_d, bw_q, bw_d, bh_q, bh_d;
  logic [W-1:0]     bx_q, bx_d, by_q, by_d, bwid_q, bwid_d, bht_q, bht_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic             phit_q, phit_d;
  logic [1:0]       pzone_q, pzone_d;

  logic             brick_ovl, pad_ovl;
  logic [W+1:0]     brick_ox, brick_oy;
  logic [W:0]       pad_ox, pad_oy;
  logic             unused_pad_depth;
  logic [W+1:0]     cx, px_ext, rel;
  logic [W+2:0]     rel3, pw1, pw2;
  logic [1:0]       zone_c;

  function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Brick test runs at W+1 bits because the running origin may exceed the W-bit range.
  aabb_overlap #(.W(W + 1)) u_brick_ovl (
    .a_x_i    ({1'b0, bx_q}),
    .a_y_i    ({1'b0, by_q}),
    .a_w_i    ({1'b0, bwid_q}),
    .a_h_i    ({1'b0, bht_q}),
    .b_x_i    (x_q),
    .b_y_i    (y_q),
    .b_w_i    ({1'b0, bw_q}),
    .b_h_i    ({1'b0, bh_q}),
    .overlap_o(brick_ovl),
    .ox_o     (brick_ox),
    .oy_o     (brick_oy)
  );

  aabb_overlap #(.W(W)) u_paddle_ovl (
    .a_x_i    (ball_x),
    .a_y_i    (ball_y),
    .a_w_i    (ball_w),
    .a_h_i    (ball_h),
    .b_x_i    (paddle_x),
    .b_y_i    (paddle_y),
    .b_w_i    (paddle_w),
    .b_h_i    (paddle_h),
    .overlap_o(pad_ovl),
    .ox_o     (pad_ox),
    .oy_o     (pad_oy)
  );

  assign unused_pad_depth = ^{pad_ox, pad_oy};

  // Thirds compared as 3*(cx - px) against w and 2w, so no divider is needed.
  always_comb begin
    cx     = {2'b00, ball_x} + {3'b000, ball_w[W-1:1]};
    px_ext = {2'b00, paddle_x};
    rel    = cx - px_ext;
    rel3   = {1'b0, rel} + {rel, 1'b0};
    pw1    = {3'b000, paddle_w};
    pw2    = {2'b00, paddle_w, 1'b0};
    zone_c = ZONE_CENTRE;
    if (cx < px_ext)      zone_c = ZONE_LEFT;
    else if (rel3 < pw1)  zone_c = ZONE_LEFT;
    else if (rel3 >= pw2) zone_c = ZONE_RIGHT;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    col_d       = col_q;
    x_d         = x_q;
    y_d         = y_q;
    gx_d        = gx_q;
    bw_d        = bw_q;
    bh_d        = bh_q;
    bx_d        = bx_q;
    by_d        = by_q;
    bwid_d      = bwid_q;
    bht_d       = bht_q;
    alive_d     = alive_q;
    left_d      = left_q;
    hit_valid_d = hit_valid_q;
    hit_idx_d   = hit_idx_q;
    flip_x_d    = flip_x_q;
    flip_y_d    = flip_y_q;
    phit_d      = phit_q;
    pzone_d     = pzone_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !load_level) begin
          state_d     = ST_SCAN;
          idx_d       = '0;
          col_d       = '0;
          x_d         = {1'b0, grid_x};
          y_d         = {1'b0, grid_y};
          gx_d        = grid_x;
          bw_d        = block_w;
          bh_d        = block_h;
          bx_d        = ball_x;
          by_d        = ball_y;
          bwid_d      = ball_w;
          bht_d       = ball_h;
          hit_valid_d = 1'b0;
          hit_idx_d   = '0;
          flip_x_d    = 1'b0;
          flip_y_d    = 1'b0;
          phit_d      = pad_ovl;
          pzone_d     = zone_c;
        end
      end
      ST_SCAN: begin
        if (!hit_valid_q && alive_q[idx_q] && brick_ovl) begin
          hit_valid_d     = 1'b1;
          hit_idx_d       = idx_q;
          alive_d[idx_q]  = 1'b0;
          left_d          = left_q - 1'b1;
          flip_x_d        = (brick_ox <= brick_oy);
          flip_y_d        = (brick_oy <= brick_ox);
        end
        idx_d = idx_q + 1'b1;
        if (col_q == IDX_W'(COLS - 1)) begin
          col_d = '0;
          x_d   = {1'b0, gx_q};
          y_d   = y_q + STEP_Y;
        end else begin
          col_d = col_q + 1'b1;
          x_d   = x_q + STEP_X;
        end
        if (idx_q == IDX_W'(N - 1)) state_d = ST_REPORT;
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A level load overrides everything, including an in-flight scan.
    if (load_level) begin
      alive_d = level_mask;
      left_d  = popcount(level_mask);
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      col_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      gx_q        <= '0;
      bw_q        <= '0;
      bh_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      bwid_q      <= '0;
      bht_q       <= '0;
      alive_q     <= '0;
      left_q      <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      flip_x_q    <= 1'b0;
      flip_y_q    <= 1'b0;
      phit_q      <= 1'b0;
      pzone_q     <= ZONE_CENTRE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      x_q         <= x_d;
      y_q         <= y_d;
      gx_q        <= gx_d;
      bw_q        <= bw_d;
      bh_q        <= bh_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      bwid_q      <= bwid_d;
      bht_q       <= bht_d;
      alive_q     <= alive_d;
      left_q      <= left_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      flip_x_q    <= flip_x_d;
      flip_y_q    <= flip_y_d;
      phit_q      <= phit_d;
      pzone_q     <= pzone_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_REPORT);
  assign hit_valid   = hit_valid_q;
  assign hit_idx     = hit_idx_q;
  assign flip_x      = flip_x_q;
  assign flip_y      = flip_y_q;
  assign paddle_hit  = phit_q;
  assign paddle_zone = pzone_q;
  assign alive       = alive_q;
  assign bricks_left = left_q;
  assign all_clear   = (alive_q == '0);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_brick_grid_collider.sv
// Scenario bench for brick_grid_collider: an integer reference model predicts each scan
// result into a queue when start is driven; the queue is popped when done arrives.
module tb_brick_grid_collider;

  localparam int W     = 10;
  localparam int COLS  = 5;
  localparam int N     = 10;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;
  localparam int EW    = 1 + IDX_W + 1 + 1 + 1 + 2 + N + CNT_W;
  localparam logic [EW-1:0] RESET_V = {1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 10'd0, 4'd0};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             load_level = 1'b0;
  logic [N-1:0]     level_mask = '0;
  logic [W-1:0]     grid_x = '0, grid_y = '0, block_w = '0, block_h = '0;
  logic [W-1:0]     ball_x = '0, ball_y = '0, ball_w = '0, ball_h = '0;
  logic [W-1:0]     paddle_x = '0, paddle_y = '0, paddle_w = '0, paddle_h = '0;
  logic             busy, done, hit_valid, flip_x, flip_y, paddle_hit, all_clear;
  logic [IDX_W-1:0] hit_idx;
  logic [1:0]       paddle_zone, state_dbg;
  logic [N-1:0]     alive;
  logic [CNT_W-1:0] bricks_left;

  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    dut_v, got, exp_v;
  logic [N-1:0]     m_alive = '0;
  int               n_checks = 0;
  int               n_pass = 0;
  int               lat;
  logic             seen;

  brick_grid_collider dut (
    .clk(clk), .rst(rst), .start(start), .load_level(load_level), .level_mask(level_mask),
    .grid_x(grid_x), .grid_y(grid_y), .block_w(block_w), .block_h(block_h),
    .ball_x(ball_x), .ball_y(ball_y), .ball_w(ball_w), .ball_h(ball_h),
    .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_w(paddle_w), .paddle_h(paddle_h),
    .busy(busy), .done(done), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .flip_x(flip_x), .flip_y(flip_y), .paddle_hit(paddle_hit), .paddle_zone(paddle_zone),
    .alive(alive), .bricks_left(bricks_left), .all_clear(all_clear), .state_dbg(state_dbg)
  );

  assign dut_v = {hit_valid, hit_idx, flip_x, flip_y, paddle_hit, paddle_zone, alive, bricks_left};

  always #5 clk = ~clk;

  function automatic bit ovl(input int ax, input int ay, input int aw, input int ah,
                             input int bx, input int by, input int bw, input int bh);
    return aw > 0 && ah > 0 && bw > 0 && bh > 0 &&
           ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah;
  endfunction

  task automatic model_push();
    int hit, x0, y0, ox, oy, bx, by, bw, bh, cx, d3;
    logic fx, fy, ph;
    logic [1:0] pz;
    logic [IDX_W-1:0] hi;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0] a;
    hit = -1; fx = 0; fy = 0; a = m_alive;
    bx = int'(ball_x); by = int'(ball_y); bw = int'(ball_w); bh = int'(ball_h);
    for (int i = 0; i < N; i++) begin
      x0 = int'(grid_x) + (i % COLS) * 128;
      y0 = int'(grid_y) + (i / COLS) * 24;
      if (hit < 0 && a[i] && ovl(bx, by, bw, bh, x0, y0, int'(block_w), int'(block_h))) begin
        ox = ((bx + bw < x0 + int'(block_w)) ? bx + bw : x0 + int'(block_w)) - ((bx > x0) ? bx : x0);
        oy = ((by + bh < y0 + int'(block_h)) ? by + bh : y0 + int'(block_h)) - ((by > y0) ? by : y0);
        hit = i; fx = (ox <= oy); fy = (oy <= ox); a[i] = 1'b0;
      end
    end
    ph = ovl(bx, by, bw, bh, int'(paddle_x), int'(paddle_y), int'(paddle_w), int'(paddle_h));
    cx = bx + bw / 2;
    if (cx < int'(paddle_x)) pz = 2'd0;
    else begin
      d3 = 3 * (cx - int'(paddle_x));
      pz = (d3 < int'(paddle_w)) ? 2'd0 : (d3 >= 2 * int'(paddle_w)) ? 2'd2 : 2'd1;
    end
    hi = (hit >= 0) ? IDX_W'(hit) : '0;
    cnt = CNT_W'($countones(a));
    m_alive = a;
    exp_q.push_back({hit >= 0, hi, fx, fy, ph, pz, a, cnt});
  endtask

  task automatic set_ball(input int x, input int y, input int w, input int h);
    ball_x = W'(x); ball_y = W'(y); ball_w = W'(w); ball_h = W'(h);
  endtask

  task automatic set_grid(input int x, input int y, input int w, input int h);
    grid_x = W'(x); grid_y = W'(y); block_w = W'(w); block_h = W'(h);
  endtask

  task automatic set_paddle(input int x, input int y, input int w, input int h);
    paddle_x = W'(x); paddle_y = W'(y); paddle_w = W'(w); paddle_h = W'(h);
  endtask

  task automatic do_load(input logic [N-1:0] m);
    @(posedge clk); #1;
    load_level = 1'b1; level_mask = m;
    @(posedge clk); #1;
    load_level = 1'b0;
    m_alive = m;
  endtask

  // Pulses start, records the prediction, and waits (bounded) for done.
  task automatic do_scan(output int cycles, output logic got_done);
    @(posedge clk); #1;
    start = 1'b1;
    model_push();
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 1'b0; cycles = -1;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; cycles = c; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (dut_v !== RESET_V) $display("FAIL reset_outputs: got %h want %h", dut_v, RESET_V);
    else n_pass++;
    n_checks++;
    if ({busy, done, all_clear, state_dbg} !== 5'b00100)
      $display("FAIL reset_status: got %b want %b", {busy, done, all_clear, state_dbg}, 5'b00100);
    else n_pass++;
    rst = 1'b1;
    m_alive = '0;
  endtask

  task automatic test_load();
    do_load(10'h3FF);
    @(negedge clk);
    n_checks++;
    if ({alive, bricks_left, all_clear} !== {10'h3FF, 4'd10, 1'b0})
      $display("FAIL load_level: got %h/%0d/%b want 3ff/10/0", alive, bricks_left, all_clear);
    else n_pass++;
  endtask

  task automatic test_top_hit();
    do_load(10'h3FF);
    set_grid(0, 0, 120, 16);
    set_paddle(0, 500, 60, 8);
    set_ball(130, 5, 8, 8);
    do_scan(lat, seen);
    n_checks++;
    if (lat != N + 1) $display("FAIL top_hit_latency: got %0d want %0d", lat, N + 1);
    else n_pass++;
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (got !== exp_v) $display("FAIL top_hit_result: got %h want %h", got, exp_v);
    else n_pass++;
    n_checks++;
    if ({hit_idx, flip_y, alive, bricks_left} !== {4'd1, 1'b1, 10'h3FD, 4'd9})
      $display("FAIL top_hit_fields: got %0d/%b/%h/%0d want 1/1/3fd/9", hit_idx, flip_y, alive, bricks_left);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, dut_v} !== {1'b0, got})
      $display("FAIL done_pulse_hold: got %b/%h want 0/%h", done, dut_v, got);
    else n_pass++;
  endtask

  task automatic test_first_only();
    do_load(10'h3FF);
    set_grid(0, 0, 120, 22);
    set_ball(8, 20, 8, 8);
    do_scan(lat, seen);
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (!seen || got !== exp_v) $display("FAIL first_only_result: got %h want %h", got, exp_v);
    else n_pass++;
    n_checks++;
    if ({hit_idx, alive[5], alive[0]} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL first_only_fields: got %0d/%b/%b want 0/1/0", hit_idx, alive[5], alive[0]);
    else n_pass++;
  endtask

  task automatic test_side_hit();
    int tbl [2][4] = '{'{116, 4, 1, 0}, '{116, 12, 1, 1}};
    for (int k = 0; k < 2; k++) begin
      do_load(10'h3FF);
      set_grid(0, 0, 120, 16);
      set_ball(tbl[k][0], tbl[k][1], 8, 8);
      do_scan(lat, seen);
      got = dut_v; exp_v = exp_q.pop_front();
      n_checks++;
      if (!seen || got !== exp_v) $display("FAIL side_hit_result_%0d: got %h want %h", k, got, exp_v);
      else n_pass++;
      n_checks++;
      if ({hit_valid, hit_idx, flip_x, flip_y} !== {1'b1, 4'd0, tbl[k][2] == 1, tbl[k][3] == 1})
        $display("FAIL side_hit_flips_%0d: got x=%b y=%b want x=%0d y=%0d", k, flip_x, flip_y, tbl[k][2], tbl[k][3]);
      else n_pass++;
    end
  endtask

  task automatic test_paddle();
    int bxs [3] = '{201, 226, 251};
    do_load(10'h3FF);
    set_grid(0, 0, 120, 16);
    set_paddle(200, 400, 60, 8);
    for (int k = 0; k < 3; k++) begin
      set_ball(bxs[k], 396, 8, 8);
      do_scan(lat, seen);
      got = dut_v; exp_v = exp_q.pop_front();
      n_checks++;
      if (!seen || got !== exp_v) $display("FAIL paddle_result_%0d: got %h want %h", k, got, exp_v);
      else n_pass++;
      n_checks++;
      if ({paddle_hit, paddle_zone, hit_valid} !== {1'b1, 2'(k), 1'b0})
        $display("FAIL paddle_zone_%0d: got hit=%b zone=%0d want hit=1 zone=%0d", k, paddle_hit, paddle_zone, k);
      else n_pass++;
    end
    set_paddle(0, 500, 60, 8);
  endtask

  task automatic test_wrap();
    do_load(10'h3FF);
    set_grid(1000, 0, 100, 16);
    set_ball(10, 5, 8, 8);
    do_scan(lat, seen);
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (!seen || got !== exp_v || hit_valid !== 1'b0)
      $display("FAIL wrap_guard: got %h want %h", got, exp_v);
    else n_pass++;
    set_grid(0, 0, 120, 16);
  endtask

  task automatic test_start_busy();
    int ndone, first;
    do_load(10'h3FF);
    set_ball(600, 100, 8, 8);
    @(posedge clk); #1;
    start = 1'b1;
    model_push();
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin ndone++; if (first < 0) first = c; end
      start = (c == 3);
    end
    start = 1'b0;
    n_checks++;
    if (ndone != 1 || first != N + 1)
      $display("FAIL start_busy: got %0d dones first at %0d want 1 at %0d", ndone, first, N + 1);
    else n_pass++;
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (got !== exp_v) $display("FAIL start_busy_result: got %h want %h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_abort();
    int ndone;
    do_load(10'h3FF);
    set_ball(600, 100, 8, 8);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    load_level = 1'b1; level_mask = 10'h2AA;
    @(posedge clk); #1;
    load_level = 1'b0;
    m_alive = 10'h2AA;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_checks++;
    if ({ndone == 0, alive, bricks_left, busy, state_dbg} !== {1'b1, 10'h2AA, 4'd5, 1'b0, 2'd0})
      $display("FAIL abort: got dones=%0d alive=%h left=%0d busy=%b want 0/2aa/5/0", ndone, alive, bricks_left, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_load(10'h3FF);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dut_v, busy, all_clear, state_dbg} !== {RESET_V, 1'b0, 1'b1, 2'd0})
      $display("FAIL reset_mid_scan: got %h busy=%b want %h busy=0", dut_v, busy, RESET_V);
    else n_pass++;
    rst = 1'b1;
    m_alive = '0;
  endtask

  task automatic test_clear_last();
    do_load(10'h200);
    set_grid(0, 0, 120, 16);
    set_ball(520, 30, 8, 8);
    do_scan(lat, seen);
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (!seen || got !== exp_v) $display("FAIL clear_last_result: got %h want %h", got, exp_v);
    else n_pass++;
    n_checks++;
    if ({all_clear, bricks_left, hit_idx} !== {1'b1, 4'd0, 4'd9})
      $display("FAIL clear_last_fields: got %b/%0d/%0d want 1/0/9", all_clear, bricks_left, hit_idx);
    else n_pass++;
    do_scan(lat, seen);
    got = dut_v; exp_v = exp_q.pop_front();
    n_checks++;
    if (lat != N + 1 || got !== exp_v || hit_valid !== 1'b0)
      $display("FAIL empty_scan: got lat=%0d %h want lat=%0d %h", lat, got, N + 1, exp_v);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      if (k % 6 == 0) do_load(N'($urandom_range(0, 1023)));
      set_ball($urandom_range(0, 700), $urandom_range(0, 60), $urandom_range(1, 16), $urandom_range(1, 16));
      set_paddle($urandom_range(0, 700), $urandom_range(0, 60), $urandom_range(3, 90), 8);
      do_scan(lat, seen);
      got = dut_v; exp_v = exp_q.pop_front();
      n_checks++;
      if (lat != N + 1 || got !== exp_v)
        $display("FAIL random_scan_%0d: got lat=%0d %h want lat=%0d %h", k, lat, got, N + 1, exp_v);
      else n_pass++;
    end
    set_paddle(0, 500, 60, 8);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_load();
    test_top_hit();
    test_first_only();
    test_side_hit();
    test_paddle();
    test_wrap();
    test_start_busy();
    test_abort();
    test_reset_mid();
    test_clear_last();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brick_grid_collider.md
Name: brick_grid_collider

Overview:
- Parametrised successor to the fixed 10-brick collision checker. Tracks a ROWS x COLS brick grid with a per-brick alive mask.
- Once per frame it scans every live brick sequentially against a latched ball box. It clears the first struck brick and reports which velocity component the ball logic must flip.
- It also reports paddle contact together with a hit zone (left, centre or right third).
- Sits between the ball/paddle position logic and the renderer and score logic.

Parameters:
- COLS, 5, bricks per row
- ROWS, 2, brick rows
- PITCH_X, 128, horizontal spacing between brick origins (pixels)
- PITCH_Y, 24, vertical spacing between brick origins (pixels)
- W, 10, coordinate width
- N (derived), ROWS*COLS, brick count
- IDX_W (derived), clog2(N), index width
- CNT_W (derived), clog2(N+1), count width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  frame pulse; latch ball/paddle boxes and begin a scan
- load_level  in  1  pulse; alive <= level_mask
- level_mask  in  N  initial alive pattern; bit i = brick i
- grid_x, grid_y  in  W  origin of brick 0
- block_w, block_h  in  W  brick size
- ball_x, ball_y, ball_w, ball_h  in  W  ball box
- paddle_x, paddle_y, paddle_w, paddle_h  in  W  paddle box
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at end of scan
- hit_valid  out  1  brick hit this scan; valid with done
- hit_idx  out  IDX_W  index of the brick hit (row*COLS+col)
- flip_x, flip_y  out  1  bounce axes; valid with done
- paddle_hit  out  1  paddle overlap; valid with done
- paddle_zone  out  2  0 left, 1 centre, 2 right; 3 never driven
- alive  out  N  current brick mask
- bricks_left  out  CNT_W  popcount of alive
- all_clear  out  1  alive == 0

Behaviour:
- Reset (rst=0 at clk edge): FSM=IDLE, alive=0, bricks_left=0, all_clear=1, busy=0, done=0, hit_valid=0, hit_idx=0, flip_x=0, flip_y=0, paddle_hit=0, paddle_zone=1.
- FSM states: IDLE -> SCAN -> REPORT -> IDLE.
- IDLE:
  - start=1: latch ball, paddle, grid and block inputs. Compute paddle_hit and zone from the latched values. Go to SCAN. Clear hit flags.
- SCAN:
  - Examines one brick per cycle, index 0..N-1 in order.
  - Brick origin is tracked with col/row counters and running x/y accumulators (add PITCH_X per column; on row wrap, reset x and add PITCH_Y). No multipliers.
  - Overlap is strict-inequality AABB, same sense as the existing checker, using the ball height for the vertical test.
  - All sums are computed in W+1 bits; no wrap-around false hits.
  - First live overlapping brick (lowest index) only:
    - Record hit_idx; clear its alive bit in that cycle.
    - Compute overlap depths ox = min(right edges) - max(left edges), oy likewise.
    - ox<oy -> flip_x; oy<ox -> flip_y; equal -> both.
  - Later overlaps in the same scan are ignored.
  - After index N-1 -> REPORT.
- REPORT:
  - done=1 for exactly one cycle; outputs are held until the next start.
  - bricks_left and all_clear already reflect the cleared brick.
  - Next state IDLE.
- busy=1 in SCAN and REPORT.
- Latency: start at cycle t -> done at cycle t+N+1.
- Paddle overlap: same AABB rule.
  - Zone from ball centre cx = ball_x + ball_w/2 relative to paddle_x: < w/3 -> 0; >= 2w/3 -> 2; else 1. Compare in W+2 bits.
- Edge cases:
  - start while busy: ignored.
  - load_level while busy: abort. FSM -> IDLE, no done pulse, alive <= level_mask.
  - load_level and start in the same cycle: load wins, start dropped.
  - alive==0 at start: full scan still runs; hit_valid=0.
  - block_w=0 or ball_w=0: never overlaps.
  - Reset mid-scan: immediate return to reset values.
- bricks_left is a registered counter: decremented on a clear, loaded with popcount on load_level. It must always equal popcount(alive).

Decomposition:
- Package brick_pkg: zone encodings (ZONE_LEFT/CENTRE/RIGHT), FSM state enum, clog2 helper, default pitch constants.
- Sub-module aabb_overlap (combinational, parameter W): inputs are two boxes; outputs are overlap, ox, oy.
  - Instantiated twice: once for the current brick, once for the paddle.

Test Plan:
- Default params; level_mask=10'h3FF; grid=(0,0); block 120x16; ball (130,5) 8x8; start -> done at t+11, hit_idx=1, flip_y=1, alive=10'h3FD, bricks_left=9.
- Ball (8,20) 8x8 overlapping bricks 0 and 5 -> only brick 0 cleared (hit_idx=0); brick 5 remains alive.
- Side hit: block at (0,0) 120x16; ball (116,4) 8x8 -> ox=4 < oy=8 -> flip_x=1, flip_y=0. Equal-depth corner -> both flips set.
- Paddle (200,400) w=60 h=8; ball centre x at 205, 230 and 255, overlapping -> zones 0, 1, 2, paddle_hit=1; no brick hit.
- Wrap guard: grid_x=1000, block_w=100, ball_x=10 -> no hit (the 10-bit sum would wrap).
- Control edges:
  - load_level at the 4th SCAN cycle -> no done; alive=level_mask.
  - start during busy -> ignored.
  - rst low mid-scan -> all reset values next cycle.
  - Clear the last brick -> all_clear=1, bricks_left=0.
